srio_nwr_req_gen: RTL and testbench



---
 rtl/srio_nwr_req_gen_if.sv | 31 +++
 rtl/srio_nwr_req_gen.sv | 147 ++++++++++++++
 tb/tb_srio_nwr_req_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/srio_nwr_req_gen_if.sv
// rtl/srio_nwr_req_gen_if.sv - payload-in and ireq-out stream bundle for srio_nwr_req_gen
interface srio_nwr_req_gen_if;
  logic [63:0] data_in;
  logic        data_valid_in;
  logic        data_first_in;
  logic [7:0]  data_keep_in;
  logic [15:0] data_len_in;
  logic        data_last_in;
  logic        data_ready_out;
  logic        ireq_tready;
  logic        ireq_tvalid;
  logic [63:0] ireq_tdata;
  logic [7:0]  ireq_tkeep;
  logic        ireq_tlast;

  // Environment side: feeds payload, accepts requests.
  modport master (
    output data_in, data_valid_in, data_first_in, data_keep_in, data_len_in, data_last_in,
    output ireq_tready,
    input  data_ready_out,
    input  ireq_tvalid, ireq_tdata, ireq_tkeep, ireq_tlast
  );

  // Request generator side.
  modport slave (
    input  data_in, data_valid_in, data_first_in, data_keep_in, data_len_in, data_last_in,
    input  ireq_tready,
    output data_ready_out,
    output ireq_tvalid, ireq_tdata, ireq_tkeep, ireq_tlast
  );
endinterface

// File: rtl/srio_nwr_req_gen.sv
// rtl/srio_nwr_req_gen.sv - splits a payload transfer into SRIO NWRITE packets (HELLO format)
module srio_nwr_req_gen #(
  parameter int MAX_BYTES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [33:0]        base_addr,
  srio_nwr_req_gen_if.slave  bus,
  output logic               done_o,
  output logic               err_o
);
  localparam int          SEG_WORDS = MAX_BYTES / 8;
  localparam logic [13:0] SEG_W14   = 14'(SEG_WORDS);
  localparam logic [33:0] ADDR_STEP = 34'(MAX_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [13:0] words_left_q, words_left_d;
  logic [33:0] addr_q, addr_d;
  logic [7:0]  tid_q, tid_d;
  logic [5:0]  beat_cnt_q, beat_cnt_d;
  logic [63:0] hdr_q, hdr_d;
  logic        err_q, err_d;
  logic        first_beat_q, first_beat_d;

  logic        start, len_zero, hdr_hs, data_hs, seg_end, xfer_end;
  logic [13:0] len_words;
  logic        keep_unused;

  // Byte enables carry no information: NWRITE always moves whole dwords.
  assign keep_unused = &bus.data_keep_in;

  function automatic logic [5:0] seg_of(input logic [13:0] w);
    return (w > SEG_W14) ? 6'(SEG_WORDS) : w[5:0];
  endfunction

  function automatic logic [63:0] make_hdr(input logic [7:0] tid, input logic [13:0] w,
                                           input logic [33:0] addr);
    logic [7:0] size;
    size = 8'({seg_of(w), 3'b000} - 9'd1);
    return {tid, 4'h5, 4'h4, 2'b01, 1'b0, 1'b0, size, 2'b00, addr};
  endfunction

  assign len_words = 14'((17'(bus.data_len_in) + 17'd7) >> 3);
  assign len_zero  = (bus.data_len_in == 16'd0);
  assign start     = (state_q == S_IDLE) && bus.data_valid_in && bus.data_first_in;
  assign hdr_hs    = (state_q == S_HDR) && bus.ireq_tready;
  assign data_hs   = (state_q == S_DATA) && bus.data_valid_in && bus.ireq_tready;
  assign seg_end   = data_hs && (beat_cnt_q == 6'd1);
  assign xfer_end  = seg_end && (words_left_q == 14'd1);

  // State and datapath registers; reset abandons any partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      addr_q       <= '0;
      tid_q        <= '0;
      beat_cnt_q   <= '0;
      hdr_q        <= '0;
      err_q        <= 1'b0;
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      addr_q       <= addr_d;
      tid_q        <= tid_d;
      beat_cnt_q   <= beat_cnt_d;
      hdr_q        <= hdr_d;
      err_q        <= err_d;
      first_beat_q <= first_beat_d;
    end
  end

  // Next-state: sizing comes only from the latched length, never from data_last_in.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !len_zero) state_d = S_HDR;
      S_HDR:   if (bus.ireq_tready) state_d = S_DATA;
      S_DATA:  if (seg_end) state_d = xfer_end ? S_DONE : S_HDR;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, address/tid advance, header build and framing-error tracking.
  always_comb begin
    words_left_d = words_left_q;
    addr_d       = addr_q;
    tid_d        = tid_q;
    beat_cnt_d   = beat_cnt_q;
    hdr_d        = hdr_q;
    err_d        = err_q;
    first_beat_d = first_beat_q;
    if (start) begin
      err_d = len_zero;
      if (!len_zero) begin
        words_left_d = len_words;
        addr_d       = base_addr;
        first_beat_d = 1'b1;
        hdr_d        = make_hdr(tid_q, len_words, base_addr);
      end
    end
    if (hdr_hs) beat_cnt_d = seg_of(words_left_q);
    if (data_hs) begin
      beat_cnt_d   = beat_cnt_q - 6'd1;
      words_left_d = words_left_q - 14'd1;
      first_beat_d = 1'b0;
      if (bus.data_last_in && (words_left_q != 14'd1)) err_d = 1'b1;
      if (!bus.data_last_in && (words_left_q == 14'd1)) err_d = 1'b1;
      if (bus.data_first_in && !first_beat_q) err_d = 1'b1;
      if (seg_end && !xfer_end) begin
        addr_d = addr_q + ADDR_STEP;
        tid_d  = tid_q + 8'd1;
        hdr_d  = make_hdr(tid_q + 8'd1, words_left_q - 14'd1, addr_q + ADDR_STEP);
      end
    end
    if (state_q == S_DONE) tid_d = tid_q + 8'd1;
  end

  // Outputs: registered header in HDR, zero-latency pass-through in DATA.
  always_comb begin
    bus.ireq_tvalid    = 1'b0;
    bus.ireq_tdata     = '0;
    bus.ireq_tlast     = 1'b0;
    bus.ireq_tkeep     = 8'hFF;
    bus.data_ready_out = 1'b0;
    done_o             = 1'b0;
    case (state_q)
      S_IDLE: bus.data_ready_out = start && len_zero && !reset;
      S_HDR: begin
        bus.ireq_tvalid = 1'b1;
        bus.ireq_tdata  = hdr_q;
      end
      S_DATA: begin
        bus.ireq_tvalid    = bus.data_valid_in;
        bus.ireq_tdata     = bus.data_in;
        bus.ireq_tlast     = (beat_cnt_q == 6'd1);
        bus.data_ready_out = bus.ireq_tready;
      end
      default: done_o = 1'b1;
    endcase
  end

  assign err_o = err_q;
endmodule

// File: tb/tb_srio_nwr_req_gen.sv
// tb/tb_srio_nwr_req_gen.sv - self-checking bench for srio_nwr_req_gen
module tb_srio_nwr_req_gen;
  logic        clk = 1'b0;
  logic        reset;
  logic [33:0] base_addr;
  logic        done_o, err_o;

  srio_nwr_req_gen_if bus();

  srio_nwr_req_gen #(.MAX_BYTES(256)) dut (
    .clk(clk), .reset(reset), .base_addr(base_addr), .bus(bus), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    logic [33:0] base;
    int          extra_last;
    bit          drop_last;
    int          extra_first;
    int          ready_pct;
    int          valid_pct;
    bit          exp_err;
    int          exp_pkts;
  } vec_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          m_tid = 0;
  int          m_pkts;
  logic [63:0] pay[$];
  beat_t       exp_q[$];
  beat_t       got_q[$];
  vec_t        tbl[12];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Reference: packet list from length arithmetic alone.
  task automatic model(input int len, input logic [33:0] base);
    int          words, off, seg;
    logic [7:0]  size;
    logic [33:0] a;
    exp_q.delete();
    words  = (len + 7) / 8;
    off    = 0;
    m_pkts = 0;
    while (off < words) begin
      seg  = (words - off > 32) ? 32 : words - off;
      size = 8'(seg * 8 - 1);
      a    = base + 34'(m_pkts * 256);
      exp_q.push_back('{{8'(m_tid + m_pkts), 4'h5, 4'h4, 2'b01, 2'b00, size, 2'b00, a}, 1'b0});
      for (int i = 0; i < seg; i++) exp_q.push_back('{pay[off + i], (i == seg - 1)});
      off += seg;
      m_pkts++;
    end
  endtask

  task automatic run_xfer(input vec_t v);
    int    words, nsrc, si, last_hs, idle_cnt;
    bit    holding, prev_stall, hdr_seen, done_seen, ended;
    beat_t prev_beat;
    words = (v.len + 7) / 8;
    nsrc  = (words == 0) ? 1 : words;
    pay.delete();
    for (int i = 0; i < nsrc; i++) pay.push_back({$urandom, $urandom});
    model(v.len, v.base);
    got_q.delete();
    si = 0; last_hs = -1; idle_cnt = 0;
    holding = 0; prev_stall = 0; hdr_seen = 0; done_seen = 0; ended = 0;
    prev_beat = '0;
    base_addr = v.base;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!holding && si < nsrc && $urandom_range(99) < v.valid_pct) holding = 1;
      bus.data_valid_in = holding;
      bus.data_in       = holding ? pay[si] : 64'h0;
      bus.data_first_in = holding && (si == 0 || si == v.extra_first);
      bus.data_last_in  = holding && ((si == words - 1 && !v.drop_last) || si == v.extra_last);
      bus.data_len_in   = 16'(v.len);
      bus.data_keep_in  = 8'($urandom);
      bus.ireq_tready   = ($urandom_range(99) < v.ready_pct);
      #1;
      if (prev_stall) begin
        check("stall_valid", bus.ireq_tvalid, 1'b1);
        check("stall_beat", {bus.ireq_tdata, bus.ireq_tlast}, prev_beat);
      end
      if (bus.ireq_tvalid) check("tkeep", bus.ireq_tkeep, 8'hFF);
      if (bus.ireq_tvalid && bus.ireq_tready) begin
        if (!hdr_seen) begin
          check("err_clear", err_o, 1'b0);
          hdr_seen = 1;
        end
        got_q.push_back('{bus.ireq_tdata, bus.ireq_tlast});
        last_hs = cyc;
      end
      prev_stall = bus.ireq_tvalid && !bus.ireq_tready;
      prev_beat  = '{bus.ireq_tdata, bus.ireq_tlast};
      if (bus.data_valid_in && bus.data_ready_out) begin
        holding = 0;
        si++;
      end
      if (done_seen) begin
        check("done_pulse", done_o, 1'b0);
        ended = 1;
        break;
      end
      if (done_o) begin
        check("done_timing", cyc, last_hs + 1);
        done_seen = 1;
      end
      if (v.len == 0 && si == nsrc) begin
        idle_cnt++;
        if (idle_cnt == 2) begin
          ended = 1;
          break;
        end
      end
    end
    bus.data_valid_in = 1'b0;
    bus.data_first_in = 1'b0;
    bus.data_last_in  = 1'b0;
    check("complete", ended, 1'b1);
    check("beat_count", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check($sformatf("beat[%0d]", i), got_q[i], exp_q[i]);
    if (v.exp_pkts >= 0) check("pkts", m_pkts, v.exp_pkts);
    check("err", err_o, v.exp_err);
    m_tid = (m_tid + m_pkts) % 256;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, bus.ireq_tvalid, 1'b0);
    check({tag, "_tlast"}, bus.ireq_tlast, 1'b0);
    check({tag, "_ready"}, bus.data_ready_out, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    vec_t v;
    //          len  base          xlast drop xfirst rdy val err pkts
    tbl[0]  = '{64,  34'h1000,      -1,  0,   -1,   100, 100, 0, 1};
    tbl[1]  = '{600, 34'h1000,      -1,  0,   -1,   100, 100, 0, 3};
    tbl[2]  = '{20,  34'h2000,      -1,  0,   -1,   100, 100, 0, 1};
    tbl[3]  = '{600, 34'h1000,      -1,  0,   -1,   50,  70,  0, 3};
    tbl[4]  = '{64,  34'h0040,       2,  0,   -1,   100, 100, 1, 1};
    tbl[5]  = '{64,  34'h0080,      -1,  0,   -1,   60,  100, 0, 1};
    tbl[6]  = '{0,   34'h0100,      -1,  0,   -1,   100, 100, 1, 0};
    tbl[7]  = '{8,   34'h0200,      -1,  1,   -1,   100, 100, 1, 1};
    tbl[8]  = '{256, 34'h3_FFFF_FF00, -1, 0,  -1,   100, 100, 0, 1};
    tbl[9]  = '{264, 34'h3_FFFF_FF00, -1, 0,  -1,   80,  80,  0, 2};
    tbl[10] = '{40,  34'h0300,      -1,  0,    3,   100, 100, 1, 1};
    tbl[11] = '{1,   34'h0400,      -1,  0,   -1,   100, 100, 0, 1};

    reset = 1'b1;
    base_addr = '0;
    bus.data_in = '0; bus.data_valid_in = 0; bus.data_first_in = 0;
    bus.data_keep_in = '0; bus.data_len_in = '0; bus.data_last_in = 0; bus.ireq_tready = 0;
    repeat (2) @(negedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_xfer(tbl[i]);

    // Reset in the middle of a packet, then a clean small transfer.
    base_addr = 34'h5000;
    @(negedge clk);
    bus.data_valid_in = 1; bus.data_first_in = 1; bus.data_len_in = 16'd64;
    bus.data_in = 64'hDEAD_BEEF_0000_0001; bus.ireq_tready = 1; bus.data_last_in = 0;
    repeat (2) @(negedge clk);
    bus.data_first_in = 0;
    @(negedge clk);
    #1 check("pre_reset_busy", bus.ireq_tvalid, 1'b1);
    reset = 1'b1;
    #1 check_idle_outputs("mid_reset");
    @(negedge clk);
    #1 check_idle_outputs("held_reset");
    bus.data_valid_in = 0;
    @(negedge clk);
    reset = 1'b0;
    m_tid = 0;
    v = '{16, 34'h1000, -1, 0, -1, 100, 100, 0, 1};
    run_xfer(v);

    for (int i = 0; i < 30; i++) begin
      v = '{int'($urandom_range(1300, 1)), {2'($urandom), 32'($urandom)}, -1, 0, -1,
            int'($urandom_range(100, 30)), int'($urandom_range(100, 30)), 0, -1};
      run_xfer(v);
    end
    // Enough short transfers to carry tid across its 255 -> 0 wrap.
    for (int i = 0; i < 260; i++) begin
      v = '{int'($urandom_range(40, 1)), {2'($urandom), 32'($urandom)}, -1, 0, -1, 100, 100, 0, -1};
      run_xfer(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
